// File: rtl/window_max_hold.sv
// window_max_hold
//   Sliding-window extreme tracker. Keeps the last `depth` accepted samples in
//   a circular buffer and reports the largest and smallest occupied entry, the
//   number of samples currently held, and a window-full flag. All outputs are
//   registered and already reflect a sample on the edge after it is accepted.
//
// Configuration macro:
//   WINDOW_MAX_HOLD_SIGNED_EN  defined   -> samples are two's complement and
//                                           max/min compare signed
//                              undefined -> unsigned compares (default)
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous active-high reset (highest priority)
//   data         in   [data_width-1:0] input sample
//   data_valid   in   accept data on this edge
//   clear        in   synchronous flush; with data_valid restarts the window
//                     holding only the presented sample
//   max          out  [data_width-1:0] largest sample in window (0 if empty)
//   min          out  [data_width-1:0] smallest sample in window (0 if empty)
//   fill_count   out  [$clog2(depth+1)-1:0] samples held, saturates at depth
//   window_full  out  high when fill_count == depth
module window_max_hold #(
  parameter int data_width = 8,
  parameter int depth      = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [data_width-1:0]        data,
  input  logic                         data_valid,
  input  logic                         clear,
  output logic [data_width-1:0]        max,
  output logic [data_width-1:0]        min,
  output logic [$clog2(depth+1)-1:0]   fill_count,
  output logic                         window_full
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(depth);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [data_width-1:0] r_buf [depth];
  logic [data_width-1:0] w_buf_nxt [depth];
  logic [depth-1:0]      r_occ, w_occ_nxt;
  logic [PW-1:0]         r_wptr, w_wptr_nxt;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic [data_width-1:0] r_max, r_min, w_max_nxt, w_min_nxt;
  logic                  w_update;
  logic                  w_has;

  // a > b under the configured signedness
  function automatic logic greater(input logic [data_width-1:0] a,
                                   input logic [data_width-1:0] b);
`ifdef WINDOW_MAX_HOLD_SIGNED_EN
    logic signed [data_width-1:0] sa;
    logic signed [data_width-1:0] sb;
    sa = a;
    sb = b;
    return sa > sb;
`else
    return a > b;
`endif
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Next window contents, pointer, occupancy, count and state
  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_occ_nxt   = r_occ;
    w_count_nxt = r_count;
    w_update    = 1'b0;
    for (int i = 0; i < depth; i++) w_buf_nxt[i] = r_buf[i];

    if (clear && data_valid) begin
      // Restart: the new sample becomes the only occupant, stored at slot 0
      w_update     = 1'b1;
      w_buf_nxt[0] = data;
      w_occ_nxt    = depth'(1);
      w_wptr_nxt   = ptr_inc('0);
      w_count_nxt  = CW'(1);
      w_state_nxt  = FILLING;
    end else if (clear) begin
      w_update    = 1'b1;
      w_occ_nxt   = '0;
      w_wptr_nxt  = '0;
      w_count_nxt = '0;
      w_state_nxt = EMPTY;
    end else if (data_valid) begin
      w_update          = 1'b1;
      w_buf_nxt[r_wptr] = data;
      w_occ_nxt[r_wptr] = 1'b1;
      w_wptr_nxt        = ptr_inc(r_wptr);
      w_count_nxt       = (r_count == DEPTH_C) ? r_count : r_count + CW'(1);
      case (r_state)
        EMPTY:   w_state_nxt = (w_count_nxt == DEPTH_C) ? FULL : FILLING;
        FILLING: w_state_nxt = (w_count_nxt == DEPTH_C) ? FULL : FILLING;
        FULL:    w_state_nxt = FULL;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Extremes over occupied entries only; stale slots are masked out by occupancy
  always_comb begin
    w_has     = 1'b0;
    w_max_nxt = '0;
    w_min_nxt = '0;
    for (int i = 0; i < depth; i++) begin
      if (w_occ_nxt[i]) begin
        if (!w_has) begin
          w_max_nxt = w_buf_nxt[i];
          w_min_nxt = w_buf_nxt[i];
          w_has     = 1'b1;
        end else begin
          if (greater(w_buf_nxt[i], w_max_nxt)) w_max_nxt = w_buf_nxt[i];
          if (greater(w_min_nxt, w_buf_nxt[i])) w_min_nxt = w_buf_nxt[i];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Window storage and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) r_buf[i] <= '0;
      r_occ   <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_max   <= '0;
      r_min   <= '0;
    end else if (w_update) begin
      for (int i = 0; i < depth; i++) r_buf[i] <= w_buf_nxt[i];
      r_occ   <= w_occ_nxt;
      r_wptr  <= w_wptr_nxt;
      r_count <= w_count_nxt;
      r_max   <= w_max_nxt;
      r_min   <= w_min_nxt;
    end
  end

  assign max         = r_max;
  assign min         = r_min;
  assign fill_count  = r_count;
  assign window_full = (r_state == FULL);

endmodule

// File: tb/tb_window_max_hold.sv
module tb_window_max_hold;

  localparam int DW = 3;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data = '0;
  logic          data_valid = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] max;
  logic [DW-1:0] min;
  logic [CW-1:0] fill_count;
  logic          window_full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    logic [CW-1:0] cnt;
    logic          full;
    string         name;
  } exp_t;

  exp_t sb[$];

  window_max_hold #(.data_width(DW), .depth(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .data        (data),
    .data_valid  (data_valid),
    .clear       (clear),
    .max         (max),
    .min         (min),
    .fill_count  (fill_count),
    .window_full (window_full)
  );

  always #5 clock = ~clock;

  // Expected extremes for the mixed-sign scenario depend on the build
`ifdef WINDOW_MAX_HOLD_SIGNED_EN
  localparam logic [DW-1:0] S2_MX = 3'b001, S2_MN = 3'b111;
  localparam logic [DW-1:0] S3_MX = 3'b001, S3_MN = 3'b110;
  localparam logic [DW-1:0] S4_MX = 3'b001, S4_MN = 3'b110;
`else
  localparam logic [DW-1:0] S2_MX = 3'b111, S2_MN = 3'b001;
  localparam logic [DW-1:0] S3_MX = 3'b111, S3_MN = 3'b001;
  localparam logic [DW-1:0] S4_MX = 3'b111, S4_MN = 3'b000;
`endif

  task automatic check_field(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are registered, so compare on the falling edge
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_field(e.name, "max", int'(max), int'(e.mx));
      check_field(e.name, "min", int'(min), int'(e.mn));
      check_field(e.name, "fill_count", int'(fill_count), int'(e.cnt));
      check_field(e.name, "window_full", int'(window_full), int'(e.full));
    end
  end

  task automatic step(input logic r, input logic c, input logic v, input logic [DW-1:0] d,
                      input logic [DW-1:0] emx, input logic [DW-1:0] emn,
                      input int ec, input logic ef, input string nm);
    exp_t e;
    @(negedge clock);
    reset = r; clear = c; data_valid = v; data = d;
    @(posedge clock);
    #1;
    e.mx = emx; e.mn = emn; e.cnt = CW'(ec); e.full = ef; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    // Reset, with a sample presented that must be discarded
    step(1, 0, 1, 3'd5, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 3'd0, 0, 0, 0, 0, "post_reset_idle");
    // Fill
    step(0, 0, 1, 3'd3, 3, 3, 1, 0, "fill1");
    step(0, 0, 1, 3'd5, 5, 3, 2, 0, "fill2");
    step(0, 0, 1, 3'd1, 5, 1, 3, 0, "fill3");
    // Plain clear
    step(0, 1, 0, 3'd6, 0, 0, 0, 0, "clear");
    // Eviction and pointer wrap
    step(0, 0, 1, 3'd7, 7, 7, 1, 0, "evict1");
    step(0, 0, 1, 3'd1, 7, 1, 2, 0, "evict2");
    step(0, 0, 1, 3'd2, 7, 1, 3, 0, "evict3");
    step(0, 0, 1, 3'd3, 7, 1, 4, 1, "evict4_full");
    step(0, 0, 1, 3'd4, 4, 1, 4, 1, "evict5_wrap");
    step(0, 0, 1, 3'd5, 5, 2, 4, 1, "evict6");
    // Clear together with valid
    step(0, 1, 1, 3'd2, 2, 2, 1, 0, "clear_valid");
    // Hold with varying data
    step(0, 0, 0, 3'd7, 2, 2, 1, 0, "hold1");
    step(0, 0, 0, 3'd0, 2, 2, 1, 0, "hold2");
    step(0, 0, 0, 3'd5, 2, 2, 1, 0, "hold3");
    // Signedness
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, "clear2");
    step(0, 0, 1, 3'b111, 3'b111, 3'b111, 1, 0, "sign1");
    step(0, 0, 1, 3'b001, S2_MX, S2_MN, 2, 0, "sign2");
    step(0, 0, 1, 3'b110, S3_MX, S3_MN, 3, 0, "sign3");
    step(0, 0, 1, 3'b000, S4_MX, S4_MN, 4, 1, "sign4_full");
    // Reset while full with a valid sample
    step(1, 0, 1, 3'd6, 0, 0, 0, 0, "reset_full");
    // Stale zeros and the discarded 6 must not show up
    step(0, 0, 1, 3'd3, 3, 3, 1, 0, "after_reset");
    step(0, 0, 1, 3'd3, 3, 3, 2, 0, "repeat");
    step(0, 0, 0, 3'd0, 3, 3, 2, 0, "repeat_hold");

    @(negedge clock);
    reset = 0; clear = 0; data_valid = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
